// File: rtl/ap_seq_pkg.sv
// ap_seq_pkg: shared types, default widths and helpers for the ap_ctrl sequencer.
//   ap_seq_state_e : sequencer FSM states
//   Def*           : default parameter values
//   sat_inc()      : saturating increment for counters up to 64 bits wide
package ap_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StFinish,
    StError
  } ap_seq_state_e;

  localparam int unsigned DefCntW           = 16;
  localparam int unsigned DefCycW           = 32;
  localparam int unsigned DefMaxOutstanding = 4;
  localparam int unsigned DefTimeoutCyc     = 100000;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/ap_seq_watchdog.sv
// ap_seq_watchdog: inactivity counter for the ap_ctrl sequencer.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_clear          : zero the counter (takes priority over i_enable)
//   i_enable         : count this cycle
//   o_expired        : counter has reached TIMEOUT_CYC (holds until cleared)
module ap_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYC);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == Limit);

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: drives an HLS kernel's ap_ctrl handshake for a host command port.
// Issues cmd_count transactions with at most MAX_OUTSTANDING in flight, counts accepted
// starts (ap_start & ap_ready) and consumed dones (ap_done & ap_continue), then pulses
// o_finish with run statistics.
// Ports:
//   i_clock, i_reset          : clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready   : run request; ready only in idle
//   i_cmd_count               : transactions to run (0 = no-op run)
//   i_abort                   : stop issuing, drain in-flight transactions
//   o_ap_start, i_ap_ready    : kernel start handshake
//   i_ap_done, o_ap_continue  : kernel done handshake
//   o_busy, o_finish          : not idle; one-cycle end-of-run pulse
//   o_aborted                 : run ended by abort or watchdog
//   o_starts_issued, o_dones_seen, o_run_cycles : run statistics
//   o_err                     : sticky watchdog error
// Optional: define AP_SEQ_WATCHDOG_EN to enable the inactivity watchdog (TIMEOUT_CYC).
module ap_ctrl_sequencer
  import ap_seq_pkg::*;
#(
  parameter int unsigned CNT_W           = DefCntW,
  parameter int unsigned CYC_W           = DefCycW,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding,
  parameter int unsigned TIMEOUT_CYC     = DefTimeoutCyc
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic             i_abort,
  output logic             o_ap_start,
  input  logic             i_ap_ready,
  input  logic             i_ap_done,
  output logic             o_ap_continue,
  output logic             o_busy,
  output logic             o_finish,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_starts_issued,
  output logic [CNT_W-1:0] o_dones_seen,
  output logic [CYC_W-1:0] o_run_cycles,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);

  ap_seq_state_e    r_state, w_state_d;
  logic [CNT_W-1:0] r_target, r_starts, r_dones;
  logic [CYC_W-1:0] r_cycles;
  logic             r_aborted;

  logic [CNT_W-1:0] w_outstanding, w_starts_inc, w_dones_inc;
  logic             w_accept, w_start_acc, w_done_acc, w_set_abort, w_wd_expired;

  assign w_accept      = (r_state == StIdle) && i_cmd_valid;
  assign w_outstanding = r_starts - r_dones;
  assign w_starts_inc  = CNT_W'(sat_inc(64'(r_starts), CNT_W));
  assign w_dones_inc   = CNT_W'(sat_inc(64'(r_dones), CNT_W));
  assign w_start_acc   = o_ap_start && i_ap_ready;
  assign w_done_acc    = i_ap_done && o_ap_continue;

  always_comb begin
    w_state_d     = r_state;
    o_ap_start    = 1'b0;
    o_ap_continue = 1'b0;
    w_set_abort   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_state_d = (i_cmd_count != '0) ? StIssue : StFinish;
        end
      end
      StIssue: begin
        // abort gates ap_start combinationally so no new start slips through
        o_ap_start    = (r_starts < r_target) && (w_outstanding < MaxOut) &&
                        !i_abort && !w_wd_expired;
        o_ap_continue = 1'b1;
        if (w_wd_expired) begin
          w_state_d = StError;
        end else if (i_abort) begin
          w_set_abort = 1'b1;
          w_state_d   = StDrain;
        end else if (o_ap_start && i_ap_ready && (w_starts_inc == r_target)) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        o_ap_continue = 1'b1;
        if (w_wd_expired) begin
          w_state_d = StError;
        end else if ((i_ap_done ? w_dones_inc : r_dones) == r_starts) begin
          w_state_d = StFinish;
        end
      end
      StFinish: w_state_d = StIdle;
      StError: begin
        w_set_abort = 1'b1;
        w_state_d   = StFinish;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_target  <= '0;
      r_starts  <= '0;
      r_dones   <= '0;
      r_cycles  <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_target  <= i_cmd_count;
        r_starts  <= '0;
        r_dones   <= '0;
        // the accept cycle itself counts as the first run cycle
        r_cycles  <= CYC_W'(1);
        r_aborted <= 1'b0;
      end else begin
        if (w_start_acc) r_starts <= w_starts_inc;
        if (w_done_acc) r_dones <= w_dones_inc;
        if (r_state != StIdle) r_cycles <= CYC_W'(sat_inc(64'(r_cycles), CYC_W));
        if (w_set_abort) r_aborted <= 1'b1;
      end
    end
  end

`ifdef AP_SEQ_WATCHDOG_EN
  logic r_err;

  ap_seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_accept || w_start_acc || w_done_acc),
    .i_enable ((r_state == StIssue) || (r_state == StDrain)),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((w_state_d == StError) && (r_state != StError)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_wd_expired     = 1'b0;
  assign o_err            = 1'b0;
`endif

  assign o_cmd_ready     = (r_state == StIdle);
  assign o_busy          = (r_state != StIdle);
  assign o_finish        = (r_state == StFinish);
  assign o_aborted       = r_aborted;
  assign o_starts_issued = r_starts;
  assign o_dones_seen    = r_dones;
  assign o_run_cycles    = r_cycles;

endmodule
